// File: rtl/byte_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : byte_queue_pkg
// Description : Shared types and constants for the byte queue that sits
//               behind the serial-to-byte deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package byte_queue_pkg;

   // Width of one deserialized byte
   localparam int BYTE_W = 8;

   // Write-side handshake states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACK      = 2'd1,
      WAIT_LOW = 2'd2
   } wq_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : byte_queue_mem
// Description : DEPTH x WIDTH register array, synchronous write port and
//               combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_queue_mem
   import byte_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = BYTE_W
) (
   input  logic                     clock_100KHz,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Store the incoming byte on a write strobe
   always_ff @(posedge clock_100KHz) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/byte_queue.sv
`default_nettype none
// ============================================================================
// Module      : byte_queue
// Description : Byte FIFO fed by the deserializer through a data_ready/ack
//               handshake and drained by dequeue requests. Ack is withheld
//               while the queue is full.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_queue
   import byte_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = BYTE_W
) (
   input  logic                         clock_100KHz,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             data_in,
   input  logic                         data_ready,
   output logic                         ack_out,
   input  logic                         dequeue_in,
   output logic [WIDTH-1:0]             data_out,
   output logic                         valid_out,
   output logic [$clog2(DEPTH+1)-1:0]   len_out,
   output logic                         full,
   output logic                         empty
);

   localparam int                 c_PTR_W    = $clog2(DEPTH);
   localparam int                 c_LEN_W    = $clog2(DEPTH + 1);
   localparam logic [c_LEN_W-1:0] c_FULL_LEN = c_LEN_W'(DEPTH);
   localparam logic [c_LEN_W-1:0] c_LEN_ONE  = c_LEN_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

   wq_state_t          r_state;
   wq_state_t          w_state_next;
   logic               w_we;
   logic               w_ack_next;
   logic               w_rd;
   logic               r_ack;
   logic               r_valid;
   logic [WIDTH-1:0]   r_data_out;
   logic [WIDTH-1:0]   w_rdata;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LEN_W-1:0] r_len;
   logic [c_LEN_W-1:0] w_len_next;
   logic               r_full;
   logic               r_empty;

   // Storage array
   byte_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clock_100KHz (clock_100KHz),
      .we           (w_we),
      .waddr        (r_wr_ptr),
      .wdata        (data_in),
      .raddr        (r_rd_ptr),
      .rdata        (w_rdata)
   );

   // Handshake state register
   always_ff @(posedge clock_100KHz or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Handshake next-state: capture once per data_ready assertion, then wait
   // for the deserializer to drop data_ready before accepting another byte
   always_comb begin
      w_state_next = r_state;
      w_we         = 1'b0;
      w_ack_next   = 1'b0;
      case (r_state)
         IDLE: begin
            if (data_ready && !r_full) begin
               w_we         = 1'b1;
               w_ack_next   = 1'b1;
               w_state_next = ACK;
            end
         end
         ACK: begin
            w_state_next = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!data_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // A dequeue only takes effect when something is stored (empty is pre-edge)
   assign w_rd = dequeue_in && !r_empty;

   // Occupancy after this edge; a write and a dequeue together cancel out
   always_comb begin
      w_len_next = r_len;
      if (w_we && !w_rd) begin
         w_len_next = r_len + c_LEN_ONE;
      end else if (!w_we && w_rd) begin
         w_len_next = r_len - c_LEN_ONE;
      end
   end

   // Pointers, occupancy and registered full/empty flags
   always_ff @(posedge clock_100KHz or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_len    <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_we) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         r_len   <= w_len_next;
         r_full  <= (w_len_next == c_FULL_LEN);
         r_empty <= (w_len_next == '0);
      end
   end

   // Output registers: ack pulse, dequeued byte and its valid pulse
   always_ff @(posedge clock_100KHz or posedge reset) begin
      if (reset) begin
         r_ack      <= 1'b0;
         r_valid    <= 1'b0;
         r_data_out <= '0;
      end else begin
         r_ack   <= w_ack_next;
         r_valid <= w_rd;
         if (w_rd) begin
            r_data_out <= w_rdata;
         end
      end
   end

   assign ack_out   = r_ack;
   assign valid_out = r_valid;
   assign data_out  = r_data_out;
   assign len_out   = r_len;
   assign full      = r_full;
   assign empty     = r_empty;

endmodule
`default_nettype wire
